// File: rtl/ecc_apb_master.sv
// APB write-only master that programs the ECC target register map, waits for
// operation_done (bounded by TIMEOUT), and returns a single-cycle response.
module ecc_apb_master #(
    parameter int AMBA_WORD       = 32,
    parameter int AMBA_ADDR_WIDTH = 20,
    parameter int DATA_WIDTH      = 32,
    parameter int TIMEOUT         = 1024
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic [1:0]                 req_op,
    input  logic [DATA_WIDTH-1:0]      req_data,
    input  logic [1:0]                 req_width,
    input  logic [DATA_WIDTH-1:0]      req_noise,
    output logic                       rsp_valid,
    output logic [DATA_WIDTH-1:0]      rsp_data,
    output logic [1:0]                 rsp_errors,
    output logic                       rsp_timeout,
    output logic [AMBA_ADDR_WIDTH-1:0] PADDR,
    output logic [AMBA_WORD-1:0]       PWDATA,
    output logic                       PSEL,
    output logic                       PENABLE,
    output logic                       PWRITE,
    input  logic                       operation_done,
    input  logic [DATA_WIDTH-1:0]      data_out,
    input  logic [1:0]                 num_of_errors
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, SETUP, ACCESS, WAIT, RESP} state_t;

    state_t                state, state_nxt;
    logic [1:0]            wr_idx;
    logic [1:0]            op_q;
    logic [1:0]            width_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic [DATA_WIDTH-1:0] noise_q;
    logic [CNT_W-1:0]      wait_cnt;
    logic                  abort_q;

    wire accept   = (state == IDLE) && req_valid;
    wire last_wr  = (wr_idx == 2'd3);
    wire time_out = (wait_cnt == CNT_LAST);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of block evaluation order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // NOTE: every comb output gets a default first so no path infers a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req_valid) state_nxt = (req_op == 2'd3) ? RESP : SETUP;
            SETUP:   state_nxt = ACCESS;
            ACCESS:  state_nxt = last_wr ? WAIT : SETUP;
            WAIT:    if (operation_done || time_out) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_idx     <= '0;
            op_q       <= '0;
            width_q    <= '0;
            data_q     <= '0;
            noise_q    <= '0;
            wait_cnt   <= '0;
            abort_q    <= 1'b0;
            rsp_data   <= '0;
            rsp_errors <= '0;
        end else begin
            if (accept) begin
                op_q    <= req_op;
                width_q <= req_width;
                data_q  <= req_data;
                noise_q <= req_noise;
                wr_idx  <= '0;
                if (req_op == 2'd3) begin
                    abort_q    <= 1'b1;
                    rsp_data   <= '0;
                    rsp_errors <= '0;
                end
            end
            if (state == ACCESS) begin
                wr_idx <= wr_idx + 2'd1;
                if (last_wr) wait_cnt <= '0;
            end
            // Done takes priority over a timeout landing in the same cycle.
            if (state == WAIT) begin
                wait_cnt <= wait_cnt + CNT_W'(1);
                if (operation_done) begin
                    abort_q    <= 1'b0;
                    rsp_data   <= data_out;
                    rsp_errors <= num_of_errors;
                end else if (time_out) begin
                    abort_q    <= 1'b1;
                    rsp_data   <= '0;
                    rsp_errors <= '0;
                end
            end
        end
    end

    // Write order: DATA_IN, CODEWORD_WIDTH, NOISE, then CTRL to launch the op.
    always_comb begin
        req_ready   = (state == IDLE);
        rsp_valid   = (state == RESP);
        rsp_timeout = (state == RESP) && abort_q;
        PSEL        = (state == SETUP) || (state == ACCESS);
        PENABLE     = (state == ACCESS);
        PWRITE      = 1'b1;
        PADDR       = '0;
        PWDATA      = '0;
        if (PSEL) begin
            case (wr_idx)
                2'd0: begin
                    PADDR  = AMBA_ADDR_WIDTH'(8'h04);
                    PWDATA = AMBA_WORD'(data_q);
                end
                2'd1: begin
                    PADDR  = AMBA_ADDR_WIDTH'(8'h08);
                    PWDATA = AMBA_WORD'(width_q);
                end
                2'd2: begin
                    PADDR  = AMBA_ADDR_WIDTH'(8'h0C);
                    PWDATA = AMBA_WORD'(noise_q);
                end
                default: begin
                    PADDR  = AMBA_ADDR_WIDTH'(8'h00);
                    PWDATA = AMBA_WORD'(op_q);
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ecc_apb_master.sv
// Directed bench for ecc_apb_master (TIMEOUT=16) with immediate-assertion checks.
module tb_ecc_apb_master;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  req_op = '0;
    logic [31:0] req_data = '0;
    logic [1:0]  req_width = '0;
    logic [31:0] req_noise = '0;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic [1:0]  rsp_errors;
    logic        rsp_timeout;
    logic [19:0] PADDR;
    logic [31:0] PWDATA;
    logic        PSEL, PENABLE, PWRITE;
    logic        operation_done = 1'b0;
    logic [31:0] data_out = '0;
    logic [1:0]  num_of_errors = '0;

    int tests = 0;
    int fails = 0;

    ecc_apb_master #(
        .AMBA_WORD(32), .AMBA_ADDR_WIDTH(20), .DATA_WIDTH(32), .TIMEOUT(16)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_data(req_data), .req_width(req_width), .req_noise(req_noise),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_errors(rsp_errors),
        .rsp_timeout(rsp_timeout),
        .PADDR(PADDR), .PWDATA(PWDATA), .PSEL(PSEL), .PENABLE(PENABLE),
        .PWRITE(PWRITE),
        .operation_done(operation_done), .data_out(data_out),
        .num_of_errors(num_of_errors)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Presents a command in IDLE; returns in cycle T+1.
    task automatic start_cmd(input logic [1:0] op, input logic [31:0] data,
                             input logic [1:0] width, input logic [31:0] noise);
        check("ready_before_cmd", req_ready, 1'b1);
        req_valid = 1'b1;
        req_op    = op;
        req_data  = data;
        req_width = width;
        req_noise = noise;
        tick();
        req_valid = 1'b0;
    endtask

    // Checks one SETUP+ACCESS pair starting in the current cycle.
    task automatic expect_write(input string tag, input logic [19:0] addr, input logic [31:0] wdata);
        check({tag, "_setup_psel"}, {PSEL, PENABLE, PWRITE}, 3'b101);
        check({tag, "_setup_paddr"}, PADDR, addr);
        check({tag, "_setup_pwdata"}, PWDATA, wdata);
        tick();
        check({tag, "_access_psel"}, {PSEL, PENABLE, PWRITE}, 3'b111);
        check({tag, "_access_paddr"}, PADDR, addr);
        check({tag, "_access_pwdata"}, PWDATA, wdata);
        tick();
    endtask

    initial begin
        // Reset values while asserted
        #3;
        check("rst_psel_penable", {PSEL, PENABLE}, 2'b00);
        check("rst_pwrite", PWRITE, 1'b1);
        check("rst_paddr", PADDR, 20'h0);
        check("rst_pwdata", PWDATA, 32'h0);
        check("rst_rsp", {rsp_valid, rsp_timeout, rsp_errors}, 4'b0000);
        check("rst_rsp_data", rsp_data, 32'h0);
        #9 rst = 1'b1;
        tick();
        check("rst_ready", req_ready, 1'b1);

        // Encode: done during T+11, response in T+12
        start_cmd(2'd0, 32'hA5, 2'd0, 32'h0);
        expect_write("enc_data", 20'h04, 32'hA5);
        expect_write("enc_width", 20'h08, 32'h0);
        expect_write("enc_noise", 20'h0C, 32'h0);
        expect_write("enc_ctrl", 20'h00, 32'h0);
        check("enc_wait_idle_bus", {PSEL, PENABLE, req_ready, rsp_valid}, 4'b0000);
        ticks(2);
        operation_done = 1'b1;
        data_out = 32'h1A5;
        num_of_errors = 2'd0;
        tick();
        operation_done = 1'b0;
        check("enc_rsp_valid", {rsp_valid, rsp_timeout}, 2'b10);
        check("enc_rsp_data", rsp_data, 32'h1A5);
        check("enc_rsp_errors", rsp_errors, 2'd0);
        tick();
        check("enc_after_rsp", {rsp_valid, req_ready}, 2'b01);
        check("enc_hold_data", rsp_data, 32'h1A5);

        // Decode with one error, done on first WAIT cycle
        start_cmd(2'd1, 32'h12, 2'd1, 32'h4);
        expect_write("dec_data", 20'h04, 32'h12);
        expect_write("dec_width", 20'h08, 32'h1);
        expect_write("dec_noise", 20'h0C, 32'h4);
        expect_write("dec_ctrl", 20'h00, 32'h1);
        operation_done = 1'b1;
        data_out = 32'h5A;
        num_of_errors = 2'd1;
        tick();
        operation_done = 1'b0;
        check("dec_rsp", {rsp_valid, rsp_timeout, rsp_errors}, 4'b1001);
        check("dec_rsp_data", rsp_data, 32'h5A);
        tick();

        // Timeout, full-channel op with width=3 passed through unchanged
        start_cmd(2'd2, 32'hDEADBEEF, 2'd3, 32'hFFFF0000);
        expect_write("to_data", 20'h04, 32'hDEADBEEF);
        expect_write("to_width", 20'h08, 32'h3);
        expect_write("to_noise", 20'h0C, 32'hFFFF0000);
        expect_write("to_ctrl", 20'h00, 32'h2);
        ticks(15);
        check("to_still_waiting", {rsp_valid, PSEL}, 2'b00);
        tick();
        check("to_rsp", {rsp_valid, rsp_timeout, rsp_errors}, 4'b1100);
        check("to_rsp_data", rsp_data, 32'h0);
        tick();
        check("to_ready_after", {req_ready, rsp_valid, rsp_timeout}, 3'b100);

        // Illegal op: immediate abort, no APB traffic
        start_cmd(2'd3, 32'h77, 2'd0, 32'h0);
        check("ill_rsp", {rsp_valid, rsp_timeout, PSEL, PENABLE}, 4'b1100);
        check("ill_rsp_data", {rsp_data, rsp_errors}, 34'h0);
        tick();
        check("ill_after", {req_ready, rsp_valid, PSEL}, 3'b100);

        // Reset during the NOISE write ACCESS
        start_cmd(2'd0, 32'h33, 2'd2, 32'h1);
        expect_write("rs_data", 20'h04, 32'h33);
        expect_write("rs_width", 20'h08, 32'h2);
        tick();
        check("rs_in_access", {PSEL, PENABLE}, 2'b11);
        #2 rst = 1'b0;
        #1;
        check("rs_async_bus", {PSEL, PENABLE, PWRITE}, 3'b001);
        check("rs_async_rsp", {rsp_valid, rsp_timeout}, 2'b00);
        tick();
        tick();
        #2 rst = 1'b1;
        tick();
        check("rs_no_rsp", {rsp_valid, req_ready, PSEL}, 3'b010);
        start_cmd(2'd0, 32'h77, 2'd2, 32'h0);
        expect_write("rs2_data", 20'h04, 32'h77);
        expect_write("rs2_width", 20'h08, 32'h2);
        expect_write("rs2_noise", 20'h0C, 32'h0);
        expect_write("rs2_ctrl", 20'h00, 32'h0);
        operation_done = 1'b1;
        data_out = 32'h1234;
        num_of_errors = 2'd0;
        tick();
        operation_done = 1'b0;
        check("rs2_rsp", {rsp_valid, rsp_timeout}, 2'b10);
        check("rs2_rsp_data", rsp_data, 32'h1234);
        tick();

        // Spurious done during first write, then done on the timeout cycle
        start_cmd(2'd1, 32'h55, 2'd0, 32'h10);
        operation_done = 1'b1;
        data_out = 32'hBAD;
        num_of_errors = 2'd3;
        expect_write("sp_data", 20'h04, 32'h55);
        operation_done = 1'b0;
        expect_write("sp_width", 20'h08, 32'h0);
        expect_write("sp_noise", 20'h0C, 32'h10);
        expect_write("sp_ctrl", 20'h00, 32'h1);
        check("sp_ignored", {rsp_valid, rsp_data}, {1'b0, 32'h1234});
        ticks(15);
        operation_done = 1'b1;
        data_out = 32'h3C;
        num_of_errors = 2'd2;
        tick();
        operation_done = 1'b0;
        check("sp_coincide_rsp", {rsp_valid, rsp_timeout, rsp_errors}, 4'b1010);
        check("sp_coincide_data", rsp_data, 32'h3C);
        tick();
        check("sp_after", {req_ready, rsp_valid}, 2'b10);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ecc_apb_master.md
ECC_APB_MASTER -- requirements
Module: ecc_apb_master

Interface
REQ-001 The block SHALL have parameters: AMBA_WORD, default 32, APB data width.
REQ-002 AMBA_ADDR_WIDTH, default 20, APB address width.
REQ-003 DATA_WIDTH, default 32, ECC data width.
REQ-004 TIMEOUT, default 1024, maximum number of WAIT cycles before abort.
REQ-005 The block SHALL have ports:
clk  in  1  single clock, all logic on the rising edge
rst  in  1  asynchronous, active-low reset
req_valid  in  1  command request
req_ready  out  1  block can accept a command
req_op  in  2  CTRL value: 0 encode, 1 decode, 2 full channel, 3 illegal
req_data  in  DATA_WIDTH  DATA_IN value
req_width  in  2  CODEWORD_WIDTH value: 0 8-bit, 1 16-bit, 2 32-bit
req_noise  in  DATA_WIDTH  NOISE value
rsp_valid  out  1  single-cycle response strobe
rsp_data  out  DATA_WIDTH  captured data_out
rsp_errors  out  2  captured num_of_errors
rsp_timeout  out  1  response is an abort (timeout or illegal op)
PADDR  out  AMBA_ADDR_WIDTH  APB address
PWDATA  out  AMBA_WORD  APB write data
PSEL  out  1  APB select
PENABLE  out  1  APB enable
PWRITE  out  1  APB write; always 1 (write-only master)
operation_done  in  1  target completion strobe
data_out  in  DATA_WIDTH  target result
num_of_errors  in  2  target error count

Function
REQ-006 The block SHALL drive the ECC target register map: CTRL 0x00, DATA_IN 0x04, CODEWORD_WIDTH 0x08, NOISE 0x0C.
REQ-007 FSM states SHALL be IDLE, SETUP, ACCESS, WAIT, RESP.
REQ-008 req_ready SHALL be 1 only in IDLE; a command is accepted on an edge with req_valid=1 in IDLE; req_* are registered at acceptance.
REQ-009 Writes SHALL be issued in fixed order: DATA_IN, CODEWORD_WIDTH, NOISE, then CTRL. The CTRL write starts the target operation.
REQ-010 Each write SHALL take exactly 2 cycles with no wait states: SETUP (PSEL=1, PENABLE=0), then ACCESS (PSEL=1, PENABLE=1).
REQ-011 PADDR and PWDATA SHALL be stable across SETUP and ACCESS.
REQ-012 The next SETUP SHALL follow the preceding ACCESS directly.
REQ-013 For acceptance at edge T, the first SETUP SHALL occupy cycle T+1 and the CTRL ACCESS SHALL occupy cycle T+8.
REQ-014 WAIT SHALL start in cycle T+9.
REQ-015 PSEL=0 and PENABLE=0 SHALL hold in IDLE, WAIT and RESP; PADDR and PWDATA are don't-care there.
REQ-016 PWDATA SHALL be zero-extended: op and width in bits [1:0], upper bits 0.
REQ-017 In WAIT, a sampled operation_done=1 SHALL capture data_out and num_of_errors and move to RESP.
REQ-018 In RESP, rsp_valid=1 and rsp_timeout=0 for exactly one cycle, then IDLE; no backpressure.
REQ-019 A WAIT cycle counter SHALL clear on WAIT entry.
REQ-020 If the counter reaches TIMEOUT without operation_done, the block SHALL go to RESP with rsp_timeout=1, rsp_data=0, rsp_errors=0.
REQ-021 If operation_done and the timeout coincide in the same cycle, done SHALL win (rsp_timeout=0).
REQ-022 operation_done asserted outside WAIT SHALL be ignored.
REQ-023 req_op=3 SHALL be accepted but produce no APB traffic: RESP in cycle T+1 with rsp_timeout=1 and rsp_data/rsp_errors=0.
REQ-024 req_width=3 SHALL be written unchanged; the target handles it.
REQ-025 rsp_data and rsp_errors SHALL hold their last captured values outside RESP.

Reset
REQ-026 rst=0 SHALL immediately force IDLE, PSEL=0, PENABLE=0, PWRITE=1, PADDR=0, PWDATA=0, req_ready=1 after release, rsp_valid=0, rsp_timeout=0, rsp_data=0, rsp_errors=0 and counter=0.
REQ-027 Reset mid-transfer SHALL abort the transfer with no response and no completion of the partial APB cycle.

Verification
REQ-028 Encode: op=0, data=0xA5, width=0, noise=0 -> writes (0x04,0xA5), (0x08,0), (0x0C,0), (0x00,0) in cycles T+1..T+8; done at T+11 with data_out=0x1A5 -> rsp_valid at T+12 with rsp_data=0x1A5.
REQ-029 Decode with error: op=1, noise=0x4, done with num_of_errors=1 -> rsp_errors=1, rsp_timeout=0.
REQ-030 Timeout: TIMEOUT=16, done never asserted -> rsp_valid with rsp_timeout=1 exactly 16 cycles after WAIT entry; req_ready=1 the next cycle.
REQ-031 Illegal op: op=3 -> no PSEL activity; rsp_valid and rsp_timeout at T+1.
REQ-032 Reset in ACCESS of the NOISE write -> PSEL/PENABLE low asynchronously; no rsp_valid; a new command after release runs the full 8-cycle sequence.
REQ-033 Spurious done during SETUP, plus done coinciding with the timeout -> the first is ignored; the second yields rsp_timeout=0 with captured data.
